// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: conditions three raw buttons into start/lap/clear events, runs the
// IDLE/RUN/PAUSE controller and the 1 Hz prescaler. Debounce enabled by STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int TICK_W    = 26,
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_lap,
  input  logic btn_clear,
  output logic increment,
  output logic trigger,
  output logic restart,
  output logic pulse,
  output logic running
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_DIV / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] evt;
  logic [1:0] vld_q;

  assign btn_raw = {btn_clear, btn_lap, btn_start};

  // Marks when the synchroniser stages hold real samples rather than reset values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 2'b00;
    end else begin
      vld_q <= {vld_q[0], 1'b1};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic s1_q;
      logic s2_q;
      logic arm_q;
      logic arm_d;

      // A button only arms once it has been seen released, so a press held
      // across reset release never produces an event.
      always_comb begin
        arm_d = arm_q | (vld_q[1] & ~s2_q);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_q  <= 1'b0;
          s2_q  <= 1'b0;
          arm_q <= 1'b0;
        end else begin
          s1_q  <= btn_raw[gi];
          s2_q  <= s1_q;
          arm_q <= arm_d;
        end
      end

`ifdef STOPWATCH_DEBOUNCE_EN
      localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
      logic            lvl_q;
      logic            lvl_d;
      logic [DB_W-1:0] db_q;
      logic [DB_W-1:0] db_d;
      logic            rise;

      always_comb begin
        lvl_d = lvl_q;
        db_d  = '0;
        rise  = 1'b0;
        if (s2_q != lvl_q) begin
          if (db_q == DB_LAST) begin
            lvl_d = s2_q;
            rise  = s2_q;
          end else begin
            db_d = db_q + DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lvl_q <= 1'b0;
          db_q  <= '0;
        end else begin
          lvl_q <= lvl_d;
          db_q  <= db_d;
        end
      end

      // The flip itself is the event so the strobe lands on the accepting edge.
      assign evt[gi] = rise & arm_q;
`else
      assign evt[gi] = s1_q & ~s2_q & arm_q;
`endif
    end
  endgenerate

  logic evt_start;
  logic evt_lap;
  logic evt_clear;

  assign evt_start = evt[0];
  assign evt_lap   = evt[1];
  assign evt_clear = evt[2];

  state_t            state_q;
  state_t            state_d;
  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;
  logic              increment_q;
  logic              increment_d;
  logic              trigger_q;
  logic              trigger_d;
  logic              restart_q;
  logic              restart_d;
  logic              pulse_q;
  logic              pulse_d;
  logic              running_q;
  logic              running_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    increment_d = 1'b0;
    trigger_d   = 1'b0;
    restart_d   = 1'b0;
    pulse_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (evt_clear) begin
          restart_d = 1'b1;
        end else if (evt_start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A stop landing on the last count still completes that second.
        increment_d = (cnt_q == TICK_LAST);
        pulse_d     = (cnt_q == TICK_HALF);
        cnt_d       = increment_d ? '0 : cnt_q + TICK_W'(1);
        trigger_d   = evt_lap;
        if (evt_start) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (evt_clear) begin
          restart_d = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else if (evt_start) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      increment_q <= 1'b0;
      trigger_q   <= 1'b0;
      restart_q   <= 1'b0;
      pulse_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      increment_q <= increment_d;
      trigger_q   <= trigger_d;
      restart_q   <= restart_d;
      pulse_q     <= pulse_d;
      running_q   <= running_d;
    end
  end

  assign increment = increment_q;
  assign trigger   = trigger_q;
  assign restart   = restart_q;
  assign pulse     = pulse_q;
  assign running   = running_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a cycle model predicts output events from the
// scheduled button events; a monitor compares whatever the DUT presents.
module tb_stopwatch_ctrl;

  localparam int TD  = 10;
  localparam int DBC = 4;
`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int LAT  = DBC + 1;
  localparam int MINH = DBC;
  localparam bit DBON = 1'b1;
`else
  localparam int LAT  = 1;
  localparam int MINH = 1;
  localparam bit DBON = 1'b0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clear = 1'b0;
  logic increment, trigger, restart, pulse, running;

  stopwatch_ctrl #(
    .TICK_DIV (TD),
    .TICK_W   (4),
    .DB_CYCLES(DBC),
    .DB_W     (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_lap  (btn_lap),
    .btn_clear(btn_clear),
    .increment(increment),
    .trigger  (trigger),
    .restart  (restart),
    .pulse    (pulse),
    .running  (running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic        inc;
    logic        pul;
    logic        trig;
    logic        rs;
    logic        run;
  } rec_t;

  rec_t     exp_q[$];
  bit [2:0] ev_sched[int];
  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  int       mode = M_IDLE;
  int       run_cyc = 0;
  bit       model_run = 1'b0;
  bit       mon_run = 1'b0;

  // Reference model: elapsed running cycles since the last clear decide the strobes.
  bit [2:0] m_ev;
  rec_t     m_r;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_ev   = ev_sched.exists(cyc) ? ev_sched[cyc] : 3'b000;
      m_r    = '0;
      m_r.cyc = cyc;
      if (mode == M_RUN) begin
        run_cyc++;
        m_r.inc  = (run_cyc % TD == 0);
        m_r.pul  = (run_cyc % TD == TD / 2);
        m_r.trig = m_ev[1];
        if (m_ev[0]) mode = M_PAUSE;
      end else if (m_ev[2]) begin
        m_r.rs  = 1'b1;
        mode    = M_IDLE;
        run_cyc = 0;
      end else if (m_ev[0]) begin
        mode = M_RUN;
      end
      m_r.run = (mode == M_RUN);
      if (m_r.inc || m_r.pul || m_r.trig || m_r.rs || (m_r.run != model_run))
        exp_q.push_back(m_r);
      model_run = m_r.run;
    end
  end

  rec_t got, want;
  initial forever begin
    @(negedge clk);
    if (rst && (increment || pulse || trigger || restart || (running != mon_run))) begin
      got      = '0;
      got.cyc  = cyc;
      got.inc  = increment;
      got.pul  = pulse;
      got.trig = trigger;
      got.rs   = restart;
      got.run  = running;
      mon_run  = running;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d inc=%0b pul=%0b trig=%0b rst=%0b run=%0b required nothing",
                 got.cyc, got.inc, got.pul, got.trig, got.rs, got.run);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          failures++;
          $display("FAIL out_event got cyc=%0d inc=%0b pul=%0b trig=%0b rst=%0b run=%0b required cyc=%0d inc=%0b pul=%0b trig=%0b rst=%0b run=%0b",
                   got.cyc, got.inc, got.pul, got.trig, got.rs, got.run,
                   want.cyc, want.inc, want.pul, want.trig, want.rs, want.run);
        end else begin
          $display("txn cyc=%0d inc=%0b pul=%0b trig=%0b rst=%0b run=%0b ok",
                   got.cyc, got.inc, got.pul, got.trig, got.rs, got.run);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tk(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic sched(input bit [2:0] w, input int k);
    ev_sched[k] = (ev_sched.exists(k) ? ev_sched[k] : 3'b000) | w;
  endtask

  task automatic drive(input bit [2:0] w);
    btn_start = w[0];
    btn_lap   = w[1];
    btn_clear = w[2];
  endtask

  task automatic press(input bit [2:0] w, input int hold, input int gap);
    drive(w);
    if (hold >= MINH) sched(w, cyc + 1 + LAT);
    tk(hold);
    drive(3'b000);
    tk(gap);
  endtask

  // High runs shorter than the debounce window; each one is an event without debounce.
  task automatic bounce(input bit [2:0] w, input int n, input int len);
    int h;
    int l;
    for (int i = 0; i < n; i++) begin
      h = (len > 0) ? len : int'($urandom_range(1, DBC - 1));
      l = (len > 0) ? len : int'($urandom_range(1, DBC - 1));
      drive(w);
      if (!DBON) sched(w, cyc + 1 + LAT);
      tk(h);
      drive(3'b000);
      tk(l);
    end
    tk(DBC + 4);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({increment, trigger, restart, pulse, running} != 5'b00000) begin
      failures++;
      $display("FAIL %s got inc=%0b trig=%0b rst=%0b pul=%0b run=%0b required all 0",
               tag, increment, trigger, restart, pulse, running);
    end
  endtask

  // Waits until a start pressed now would land with the given count before its edge.
  task automatic wait_phase(input int ph);
    int i;
    i = 0;
    while (!(mode == M_RUN && (run_cyc + LAT) % TD == ph) && i < 4 * TD) begin
      tk(1);
      i++;
    end
    if (i >= 4 * TD) begin
      checks++;
      failures++;
      $display("FAIL wait_phase got mode=%0d run=%0d required RUN phase %0d", mode, run_cyc, ph);
    end
  endtask

  task automatic wait_count(input int c);
    int i;
    i = 0;
    while (!(mode == M_RUN && run_cyc % TD == c) && i < 4 * TD) begin
      tk(1);
      i++;
    end
    if (i >= 4 * TD) begin
      checks++;
      failures++;
      $display("FAIL wait_count got mode=%0d run=%0d required RUN count %0d", mode, run_cyc, c);
    end
  endtask

  initial begin
    int b;
    #1 rst = 1'b0;
    #23;
    check_zero("reset_state");
    @(negedge clk);
    #2 rst = 1'b1;
    tk(6);

    // start and hold, then free-run several seconds
    press(3'b001, MINH + 3, DBC + 4);
    tk(25);
    // lap bounce while running, then a clean lap
    bounce(3'b010, 4, 3);
    press(3'b010, MINH + 1, DBC + 4);
    // pause mid-second, long wait, resume
    wait_phase(5);
    press(3'b001, MINH, DBC + 4);
    tk(50);
    press(3'b001, MINH, DBC + 4);
    tk(20);
    // lap and start together in RUN
    press(3'b011, MINH + 1, DBC + 4);
    // clear and start together in PAUSE
    press(3'b101, MINH + 1, DBC + 4);
    // clear ignored while running
    press(3'b001, MINH, DBC + 4);
    tk(12);
    press(3'b100, MINH + 1, DBC + 4);
    tk(15);
    // stop on the tick cycle, then resume
    wait_phase(9);
    press(3'b001, MINH, DBC + 4);
    tk(10);
    press(3'b001, MINH, DBC + 4);
    tk(15);

    for (int n = 0; n < 40; n++) begin
      b = 1 << $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0)
        bounce(3'(b), int'($urandom_range(1, 4)), 0);
      else
        press(3'(b), MINH + int'($urandom_range(0, 6)), DBC + 4 + int'($urandom_range(0, 8)));
    end

    // asynchronous reset mid-count with start held across release
    if (mode != M_RUN) press(3'b001, MINH, DBC + 4);
    wait_count(7);
    rst = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    ev_sched.delete();
    mode      = M_IDLE;
    run_cyc   = 0;
    model_run = 1'b0;
    mon_run   = 1'b0;
    btn_start = 1'b1;
    tk(3);
    rst = 1'b1;
    tk(20);
    check_zero("held_across_reset");
    btn_start = 1'b0;
    tk(DBC + 4);
    press(3'b001, MINH + 2, DBC + 4);
    tk(30);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected got %0d pending required 0 (next cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
